// File: rtl/fwd_scoreboard.sv
// Operand forwarding select and multi-cycle result scoreboard beside EX.
// Stalls on load-use, reads of in-flight registers and WAW on issue.
module fwd_scoreboard #(
    parameter int NUM_SRC = 3,
    parameter int STAGES  = 2,
    parameter int MAX_LAT = 31,
    localparam int LW     = $clog2(MAX_LAT + 1),
    localparam int SW     = $clog2(STAGES + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_SRC*6-1:0]   src_tag_i,
    input  logic [NUM_SRC-1:0]     src_used_i,
    input  logic [STAGES*6-1:0]    stg_tag_i,
    input  logic [STAGES-1:0]      stg_wen_i,
    input  logic [STAGES-1:0]      stg_rdy_i,
    input  logic                   issue_i,
    input  logic [5:0]             issue_tag_i,
    input  logic [LW-1:0]          issue_lat_i,
    input  logic                   flush_i,
    output logic [NUM_SRC*SW-1:0]  fwd_sel_o,
    output logic                   stall_o,
    output logic                   sb_busy_o
);

    logic [LW-1:0] cnt     [64];
    logic [LW-1:0] cnt_nxt [64];
    logic [63:0]   busy;
    logic [5:0]    tag;
    logic [SW:0]   res;
    logic          load_use;
    logic          raw;
    logic          waw;
    logic          accept;
    logic [LW-1:0] lat_eff;

    // Youngest matching writer wins; MSB of result flags a not-yet-ready writer.
    function automatic logic [SW:0] scan(input logic [5:0] t);
        logic        hit;
        logic [SW:0] r;
        hit = 1'b0;
        r   = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (!hit && stg_wen_i[s] && stg_tag_i[s*6 +: 6] == t) begin
                hit = 1'b1;
                if (stg_rdy_i[s]) r[SW-1:0] = SW'(s + 1);
                else              r[SW]     = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 64; i++) begin
            busy[i] = (cnt[i] != '0);
        end
    end

    always_comb begin
        fwd_sel_o = '0;
        load_use  = 1'b0;
        raw       = 1'b0;
        tag       = '0;
        res       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            tag = src_tag_i[k*6 +: 6];
            res = '0;
            if (src_used_i[k] && tag != 6'd0) begin
                res = scan(tag);
                fwd_sel_o[k*SW +: SW] = res[SW-1:0];
                load_use = load_use | res[SW];
                raw      = raw | busy[tag];
            end
        end
    end

    assign waw     = issue_i && busy[issue_tag_i];
    assign stall_o = load_use || raw || waw;
    assign accept  = issue_i && !stall_o && issue_tag_i != 6'd0;
    assign lat_eff = (issue_lat_i == '0) ? LW'(1) : issue_lat_i;
    assign sb_busy_o = |busy;

    always_comb begin
        for (int i = 0; i < 64; i++) begin
            cnt_nxt[i] = busy[i] ? cnt[i] - LW'(1) : '0;
        end
        if (accept) cnt_nxt[issue_tag_i] = lat_eff;
        if (flush_i) begin
            for (int i = 0; i < 64; i++) cnt_nxt[i] = '0;
        end
        cnt_nxt[0] = '0;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 64; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 64; i++) cnt[i] <= cnt_nxt[i];
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: forwarding priority, hazards,
// scoreboard countdown, WAW, flush and asynchronous reset.
module tb_fwd_scoreboard;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [17:0] src_tag_i;
    logic [2:0]  src_used_i;
    logic [11:0] stg_tag_i;
    logic [1:0]  stg_wen_i;
    logic [1:0]  stg_rdy_i;
    logic        issue_i;
    logic [5:0]  issue_tag_i;
    logic [4:0]  issue_lat_i;
    logic        flush_i;
    logic [5:0]  fwd_sel_o;
    logic        stall_o;
    logic        sb_busy_o;

    int checks = 0;
    int errors = 0;

    fwd_scoreboard dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .src_tag_i   (src_tag_i),
        .src_used_i  (src_used_i),
        .stg_tag_i   (stg_tag_i),
        .stg_wen_i   (stg_wen_i),
        .stg_rdy_i   (stg_rdy_i),
        .issue_i     (issue_i),
        .issue_tag_i (issue_tag_i),
        .issue_lat_i (issue_lat_i),
        .flush_i     (flush_i),
        .fwd_sel_o   (fwd_sel_o),
        .stall_o     (stall_o),
        .sb_busy_o   (sb_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string t, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    function automatic logic [1:0] sel(input int k);
        return fwd_sel_o[2*k +: 2];
    endfunction

    task automatic idle();
        src_tag_i   = '0;
        src_used_i  = '0;
        stg_tag_i   = '0;
        stg_wen_i   = '0;
        stg_rdy_i   = '0;
        issue_i     = 1'b0;
        issue_tag_i = '0;
        issue_lat_i = '0;
        flush_i     = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step();
        @(negedge clk_i);
    endtask

    initial begin
        reset_i = 1'b0;
        idle();
        #12;
        chk("rst_busy", sb_busy_o, 0);
        chk("rst_sel", fwd_sel_o, 0);
        chk("rst_stall", stall_o, 0);
        step();
        reset_i = 1'b1;

        // Priority: both stages write {0,5}
        step();
        stg_tag_i = {6'h05, 6'h05};
        stg_wen_i = 2'b11;
        stg_rdy_i = 2'b11;
        src_tag_i = {12'h0, 6'h05};
        src_used_i = 3'b001;
        #1;
        chk("prio_sel0", sel(0), 1);
        chk("prio_stall", stall_o, 0);
        stg_wen_i = 2'b10;
        #1;
        chk("old_sel0", sel(0), 2);

        // Bank and x0 separation
        stg_tag_i = {6'h00, 6'h23};
        stg_wen_i = 2'b01;
        src_tag_i = {12'h0, 6'h03};
        #1;
        chk("bank_sel0", sel(0), 0);
        stg_tag_i = {6'h00, 6'h00};
        src_tag_i = {12'h0, 6'h00};
        #1;
        chk("x0_sel0", sel(0), 0);
        chk("x0_stall", stall_o, 0);
        stg_tag_i = {6'h00, 6'h20};
        src_tag_i = {12'h0, 6'h20};
        #1;
        chk("f0_sel0", sel(0), 1);

        // Load-use on src1
        stg_tag_i = {6'h00, 6'h07};
        stg_rdy_i = 2'b00;
        src_tag_i = {6'h0, 6'h07, 6'h0};
        src_used_i = 3'b010;
        #1;
        chk("lu_stall", stall_o, 1);
        chk("lu_sel1", sel(1), 0);
        src_used_i = 3'b000;
        #1;
        chk("lu_unused", stall_o, 0);

        // Scoreboard RAW: {1,9} latency 4
        step();
        idle();
        issue_i = 1'b1;
        issue_tag_i = 6'h29;
        issue_lat_i = 5'd4;
        #1;
        chk("iss_stall", stall_o, 0);
        step();
        idle();
        src_tag_i = {12'h0, 6'h29};
        src_used_i = 3'b001;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("raw_stall_t%0d", c), stall_o, 1);
            chk($sformatf("raw_busy_t%0d", c), sb_busy_o, 1);
            step();
        end
        #1;
        chk("raw_free_stall", stall_o, 0);
        chk("raw_free_busy", sb_busy_o, 0);

        // Latency 0 is treated as 1
        step();
        idle();
        issue_i = 1'b1;
        issue_tag_i = 6'h11;
        step();
        idle();
        #1;
        chk("lat0_busy", sb_busy_o, 1);
        step();
        #1;
        chk("lat0_free", sb_busy_o, 0);

        // x0 is never scoreboarded
        step();
        issue_i = 1'b1;
        issue_tag_i = 6'h00;
        issue_lat_i = 5'd5;
        step();
        idle();
        #1;
        chk("x0_noscb", sb_busy_o, 0);

        // WAW: second issue to busy {1,9} must not reload
        step();
        issue_i = 1'b1;
        issue_tag_i = 6'h29;
        issue_lat_i = 5'd3;
        step();
        issue_lat_i = 5'd20;
        #1;
        chk("waw_stall", stall_o, 1);
        step();
        idle();
        #1;
        chk("waw_busy_a", sb_busy_o, 1);
        step();
        #1;
        chk("waw_busy_b", sb_busy_o, 1);
        step();
        #1;
        chk("waw_noreload", sb_busy_o, 0);

        // Flush clears pending entries from the next cycle
        issue_i = 1'b1;
        issue_tag_i = 6'h29;
        issue_lat_i = 5'd10;
        step();
        idle();
        flush_i = 1'b1;
        #1;
        chk("fl_busy_now", sb_busy_o, 1);
        step();
        flush_i = 1'b0;
        #1;
        chk("fl_busy_next", sb_busy_o, 0);

        // Issue and flush together: flush wins
        issue_i = 1'b1;
        issue_tag_i = 6'h05;
        issue_lat_i = 5'd5;
        flush_i = 1'b1;
        step();
        idle();
        #1;
        chk("iss_fl_busy", sb_busy_o, 0);

        // Async reset mid-count, between edges
        step();
        issue_i = 1'b1;
        issue_tag_i = 6'h29;
        issue_lat_i = 5'd10;
        step();
        idle();
        src_tag_i = {12'h0, 6'h29};
        src_used_i = 3'b001;
        #1;
        chk("ar_pre_stall", stall_o, 1);
        #1;
        reset_i = 1'b0;
        #1;
        chk("ar_busy", sb_busy_o, 0);
        chk("ar_stall", stall_o, 0);
        step();
        reset_i = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
